regfile_sb: RTL and testbench

//  Parametrised register file for the processor datapath. It has NRD combinational read ports and one write port.
//  It adds an asynchronous clear, optional hard-wired zero register, write-through bypass, and a per-register

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_sb_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 67 ++++++
 tb/tb_regfile_sb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its busy scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int MAX_DEPTH  = 64;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: reserve at issue, release at writeback, flush clears all.
module rf_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic                    rsv_en_i,
    input  logic [ADDR_W-1:0]       rsv_addr_i,
    input  logic                    flush_i,
    output logic [(1<<ADDR_W)-1:0]  busy_o,
    output logic [ADDR_W:0]         busy_cnt_o,
    output logic                    rsv_err_o
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wr_ok, rsv_ok, released;

    always_comb begin
        wr_ok    = wr_en_i && !(ZERO_REG != 0 && wr_addr_i == '0);
        rsv_ok   = rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == '0);
        released = wr_ok && (wr_addr_i == rsv_addr_i);
        // Later assignments win: flush > reserve > write-release.
        busy_d = busy_q;
        if (wr_ok) busy_d[wr_addr_i] = 1'b0;
        if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
        if (flush_i) busy_d = '0;
        err_d = err_q;
        if (rsv_ok && !flush_i && busy_q[rsv_addr_i] && !released) begin
            err_d = 1'b1;
        end
        cnt_d = CW'(popcount(MAX_DEPTH'(busy_d)));
    end

    always_ff @(negedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;
    assign rsv_err_o  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, write-through bypass and
// a busy scoreboard for RAW hazard detection; state updates on the falling edge.
module regfile_sb import regfile_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic                   flush,
    output logic [ADDR_W:0]        busy_cnt,
    output logic                   rsv_err
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            (BYPASS != 0 && wr_ok && a == wr_addr) ? wr_data : mem_q[a];
        assign rd_busy[k] = busy[a];
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clock_i    (clock),
        .reset_i    (reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt),
        .rsv_err_o  (rsv_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: default, zero-reg/no-bypass and wide configs.
`timescale 1ns/100ps
module tb_regfile_sb;

    logic clock = 1'b1;
    always #5 clock = ~clock;

    logic        reset;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data, z_rd_data;
    logic [1:0]  rd_busy, z_rd_busy;
    logic        wr_en, rsv_en, flush;
    logic [2:0]  wr_addr, rsv_addr;
    logic [15:0] wr_data;
    logic [3:0]  busy_cnt, z_cnt;
    logic        rsv_err, z_err;

    logic [11:0] w_rd_addr;
    logic [95:0] w_rd_data;
    logic [2:0]  w_rd_busy;
    logic        w_wr_en, w_rsv_en, w_flush;
    logic [3:0]  w_wr_addr, w_rsv_addr;
    logic [31:0] w_wr_data;
    logic [4:0]  w_cnt;
    logic        w_err;

    regfile_sb u_m (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy_cnt(busy_cnt), .rsv_err(rsv_err)
    );

    regfile_sb #(.ZERO_REG(1), .BYPASS(0)) u_z (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(z_rd_data),
        .rd_busy(z_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy_cnt(z_cnt), .rsv_err(z_err)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .NRD(3)) u_w (
        .clock(clock), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .rd_busy(w_rd_busy), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data), .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
        .flush(w_flush), .busy_cnt(w_cnt), .rsv_err(w_err)
    );

    typedef enum {
        M_RD0, M_RD1, M_BUSY0, M_BUSY1, M_CNT, M_ERR,
        Z_RD0, Z_RD1, Z_BUSY0, Z_CNT, Z_ERR,
        W_RD0, W_RD1, W_RD2, W_CNT
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic logic [31:0] obs(input sel_e s);
        case (s)
            M_RD0:   return {16'd0, rd_data[15:0]};
            M_RD1:   return {16'd0, rd_data[31:16]};
            M_BUSY0: return {31'd0, rd_busy[0]};
            M_BUSY1: return {31'd0, rd_busy[1]};
            M_CNT:   return {28'd0, busy_cnt};
            M_ERR:   return {31'd0, rsv_err};
            Z_RD0:   return {16'd0, z_rd_data[15:0]};
            Z_RD1:   return {16'd0, z_rd_data[31:16]};
            Z_BUSY0: return {31'd0, z_rd_busy[0]};
            Z_CNT:   return {28'd0, z_cnt};
            Z_ERR:   return {31'd0, z_err};
            W_RD0:   return w_rd_data[31:0];
            W_RD1:   return w_rd_data[63:32];
            W_RD2:   return w_rd_data[95:64];
            W_CNT:   return {27'd0, w_cnt};
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    function automatic logic [31:0] wdat(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203) ^ 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input sel_e s, input logic [31:0] e);
        sb_t t;
        t.tag = tag;
        t.sel = s;
        t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic drain();
        sb_t t;
        #0.2;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            chk(t.tag, obs(t.sel), t.exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        rd_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
        w_rd_addr = '0; w_wr_en = 1'b0; w_rsv_en = 1'b0; w_flush = 1'b0;
        w_wr_addr = '0; w_rsv_addr = '0; w_wr_data = '0;
        #12 reset = 1'b0;

        // 1: populate state, then asynchronous reset mid-cycle
        cyc();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'($urandom);
        rsv_en = 1'b1; rsv_addr = 3'd1;
        cyc();
        wr_addr = 3'd3; wr_data = 16'($urandom);
        cyc();
        push("pre_rst_err", M_ERR, 1);
        push("pre_rst_cnt", M_CNT, 1);
        drain();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'($urandom); rsv_en = 1'b0;
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr[2:0] = 3'(i);
            push("rst_rd", M_RD0, 0);
            drain();
        end
        push("rst_cnt", M_CNT, 0);
        push("rst_err", M_ERR, 0);
        drain();
        reset = 1'b0;

        // 2: write/read and write-through bypass
        cyc();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        cyc();
        idle();
        rd_addr = {3'd0, 3'd3};
        push("rd_beef", M_RD0, 16'hBEEF);
        push("z_rd_beef", Z_RD0, 16'hBEEF);
        drain();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        rd_addr = {3'd5, 3'd3};
        push("bypass", M_RD1, 16'h1234);
        push("z_nobypass", Z_RD1, 0);
        drain();
        cyc();
        idle();
        push("rd_1234", M_RD1, 16'h1234);
        push("z_rd_1234", Z_RD1, 16'h1234);
        drain();

        // 3: reserve/release and sticky rsv_err
        rsv_en = 1'b1; rsv_addr = 3'd2;
        cyc();
        idle();
        rd_addr = {3'd0, 3'd2};
        push("rsv_busy", M_BUSY0, 1);
        push("rsv_cnt", M_CNT, 1);
        drain();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        push("busy_no_bypass", M_BUSY0, 1);
        drain();
        cyc();
        idle();
        push("rel_busy", M_BUSY0, 0);
        push("rel_cnt", M_CNT, 0);
        push("rel_err", M_ERR, 0);
        push("rel_rd", M_RD0, 16'h2222);
        drain();
        rsv_en = 1'b1; rsv_addr = 3'd2;
        cyc();
        cyc();
        idle();
        push("dbl_err", M_ERR, 1);
        push("z_dbl_err", Z_ERR, 1);
        drain();
        cyc();
        push("err_sticky", M_ERR, 1);
        drain();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        push("rst2_err", M_ERR, 0);
        push("rst2_cnt", M_CNT, 0);
        drain();

        // 4: simultaneous write/reserve, flush priority
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        rsv_en = 1'b1; rsv_addr = 3'd4;
        cyc();
        idle();
        rd_addr = {3'd0, 3'd4};
        push("wr_rsv_rd", M_RD0, 16'h4444);
        push("wr_rsv_busy", M_BUSY0, 1);
        push("wr_rsv_err", M_ERR, 0);
        push("wr_rsv_cnt", M_CNT, 1);
        drain();
        rsv_en = 1'b1; rsv_addr = 3'd1;
        cyc();
        rsv_addr = 3'd7;
        cyc();
        idle();
        push("cnt3", M_CNT, 3);
        drain();
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd6;
        cyc();
        idle();
        rd_addr = {3'd6, 3'd4};
        push("flush_cnt", M_CNT, 0);
        push("flush_b6", M_BUSY1, 0);
        push("flush_b4", M_BUSY0, 0);
        push("flush_err", M_ERR, 0);
        drain();
        rsv_en = 1'b1; rsv_addr = 3'd7;
        cyc();
        flush = 1'b1;
        cyc();
        idle();
        push("flush_rsv_busy_err", M_ERR, 0);
        push("flush_rsv_busy_cnt", M_CNT, 0);
        drain();
        flush = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
        cyc();
        idle();
        push("flush_wr", M_RD1, 16'h6666);
        drain();

        // 5: hard-wired zero register
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_addr = {3'd0, 3'd0};
        push("r0_bypass", M_RD0, 16'hFFFF);
        push("z_r0_bypass", Z_RD0, 0);
        drain();
        cyc();
        idle();
        push("r0_rd", M_RD0, 16'hFFFF);
        push("z_r0_rd", Z_RD0, 0);
        drain();
        rsv_en = 1'b1; rsv_addr = 3'd0;
        cyc();
        push("z_r0_busy", Z_BUSY0, 0);
        push("z_r0_cnt", Z_CNT, 0);
        push("r0_busy", M_BUSY0, 1);
        push("r0_cnt", M_CNT, 1);
        drain();
        cyc();
        idle();
        push("z_r0_err", Z_ERR, 0);
        push("r0_err", M_ERR, 1);
        push("z_r0_rd2", Z_RD0, 0);
        push("z_r0_cnt2", Z_CNT, 0);
        drain();

        // 6: wide configuration, full-depth scoreboard
        for (int i = 0; i < 16; i++) begin
            w_rsv_en = 1'b1; w_rsv_addr = 4'(i);
            cyc();
            if (i == 7) begin
                push("w_cnt8", W_CNT, 8);
                drain();
            end
        end
        w_rsv_en = 1'b0;
        push("w_cnt16", W_CNT, 16);
        drain();
        for (int i = 0; i < 16; i++) begin
            w_wr_en = 1'b1; w_wr_addr = 4'(i); w_wr_data = wdat(i);
            cyc();
        end
        w_wr_en = 1'b0;
        push("w_cnt0", W_CNT, 0);
        drain();
        for (int i = 0; i < 16; i++) begin
            w_rd_addr = {4'(i + 11), 4'(i + 5), 4'(i)};
            push("w_rd0", W_RD0, wdat(i));
            push("w_rd1", W_RD1, wdat((i + 5) % 16));
            push("w_rd2", W_RD2, wdat((i + 11) % 16));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
